// File: rtl/mem_access_ctrl.sv
// Load/store controller between a byte-addressed request port and a word-wide memory.
// Sub-word stores use read-modify-write; sub-word loads are lane-extracted and extended.

module mac_lane (
  input  logic       en,
  input  logic [7:0] old_b,
  input  logic [7:0] new_b,
  output logic [7:0] out_b
);
  assign out_b = en ? new_b : old_b;
endmodule

module mem_access_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 3,
  parameter int WR_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              op,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int NB      = DATA_W / 8;
  localparam int LANE_W  = $clog2(NB);
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);

  typedef enum logic [2:0] {IDLE, RD_WAIT, MERGE, WR_WAIT, RESP} state_t;

  state_t             state, nxt;
  logic [CNT_W-1:0]   cnt;
  logic               op_q, sext_q, err_q;
  logic [1:0]         size_q;
  logic [LANE_W-1:0]  lane_q;
  logic [DATA_W-1:0]  wdata_q, rd_q;
  logic               accept, bad, cnt_z;

  assign accept = (state == IDLE) && req;
  assign cnt_z  = (cnt == '0);
  assign bad    = (size == 2'b11) ||
                  ((size == 2'b01) && addr[0]) ||
                  ((size == 2'b00) && (addr[LANE_W-1:0] != '0));

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  // next state; rejected requests spend one cycle in MERGE so the error
  // response lands one edge after acceptance, like every other path
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (req) begin
                 if (bad)                    nxt = MERGE;
                 else if (op && size == 2'b00) nxt = WR_WAIT;
                 else                        nxt = RD_WAIT;
               end
      RD_WAIT: if (cnt_z) nxt = op_q ? MERGE : RESP;
      MERGE:   nxt = err_q ? RESP : WR_WAIT;
      WR_WAIT: if (cnt_z) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // outputs decoded from state so reset drops them without a clock
  always_comb begin
    ready     = (state == IDLE);
    done      = (state == RESP);
    err       = (state == RESP) && err_q;
    mem_write = (state == WR_WAIT);
  end

  // wait counter: reloaded on every entry to a wait state, saturates at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   cnt <= '0;
    else if (nxt == RD_WAIT && state != RD_WAIT)  cnt <= RD_LOAD;
    else if (nxt == WR_WAIT && state != WR_WAIT)  cnt <= WR_LOAD;
    else if ((state == RD_WAIT || state == WR_WAIT) && !cnt_z)
                                                  cnt <= cnt - 1'b1;
  end

  // load lane extraction
  logic [NB-1:0][7:0] rw;
  logic [LANE_W-1:0]  hl0, hl1;
  logic [7:0]         byte_v;
  logic [15:0]        half_v;
  logic [DATA_W-1:0]  ld_val;

  assign rw     = mem_rdata;
  assign hl0    = {lane_q[LANE_W-1:1], 1'b0};
  assign hl1    = {lane_q[LANE_W-1:1], 1'b1};
  assign byte_v = rw[lane_q];
  assign half_v = {rw[hl1], rw[hl0]};

  always_comb begin
    case (size_q)
      2'b00:   ld_val = mem_rdata;
      2'b01:   ld_val = {{(DATA_W-16){sext_q & half_v[15]}}, half_v};
      default: ld_val = {{(DATA_W-8){sext_q & byte_v[7]}}, byte_v};
    endcase
  end

  // store merge: per-lane replace of the sampled word
  logic [NB-1:0][7:0] old_w, mrg_w;
  assign old_w = rd_q;

  for (genvar k = 0; k < NB; k++) begin : g_lane
    localparam logic [LANE_W-1:0] KL = LANE_W'(k);
    logic       en;
    logic [7:0] nb;
    assign en = (size_q == 2'b01) ? (lane_q[LANE_W-1:1] == KL[LANE_W-1:1])
                                  : (lane_q == KL);
    assign nb = (size_q == 2'b01 && KL[0]) ? wdata_q[15:8] : wdata_q[7:0];
    mac_lane u_lane (.en(en), .old_b(old_w[k]), .new_b(nb), .out_b(mrg_w[k]));
  end

  // request latches and memory-side datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= 1'b0;
      sext_q    <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= '0;
      lane_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (accept) begin
        op_q     <= op;
        sext_q   <= sext;
        size_q   <= size;
        lane_q   <= addr[LANE_W-1:0];
        wdata_q  <= wdata;
        err_q    <= bad;
        mem_addr <= {addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
        if (op && size == 2'b00 && !bad) mem_wdata <= wdata;
      end
      if (state == RD_WAIT && cnt_z) begin
        rd_q <= mem_rdata;
        if (!op_q) rdata <= ld_val;
      end
      if (state == MERGE && !err_q) mem_wdata <= mrg_w;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl at DATA_W=32, RD_LAT=3, WR_LAT=1.

module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0, op = 1'b0, sext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic        ready, done, err, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [31:0] mem_word = '0;

  int nvec = 0, nerr = 0;
  int wr_cnt = 0, done_cnt = 0;
  logic [31:0] wr_data = '0;

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .RD_LAT(3), .WR_LAT(1)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_rdata(mem_word)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_write) begin wr_cnt++; wr_data = mem_wdata; end
    if (done) done_cnt++;
  end

  task automatic access(input logic o, input logic [1:0] s, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin @(negedge clk); n++; end
    req = 1'b1; op = o; size = s; sext = sx; addr = a; wdata = wd;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset;
    nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL rst_ready got %b want 1", ready); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_done got %b want 0", done); end
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL rst_err got %b want 0", err); end
    nvec++; if (mem_write !== 1'b0) begin nerr++; $display("FAIL rst_mem_write got %b want 0", mem_write); end
    nvec++; if (rdata !== 32'h0) begin nerr++; $display("FAIL rst_rdata got %h want 0", rdata); end
    nvec++; if (mem_addr !== 32'h0) begin nerr++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
    nvec++; if (mem_wdata !== 32'h0) begin nerr++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_word_load;
    int lat, w0;
    mem_word = 32'h8000FF7F; w0 = wr_cnt;
    access(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, lat);
    nvec++; if (lat !== 3) begin nerr++; $display("FAIL wl_latency got %0d want 3", lat); end
    nvec++; if (rdata !== 32'h8000FF7F) begin nerr++; $display("FAIL wl_rdata got %h want 8000ff7f", rdata); end
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL wl_err got %b want 0", err); end
    nvec++; if (mem_addr !== 32'h10) begin nerr++; $display("FAIL wl_mem_addr got %h want 00000010", mem_addr); end
    nvec++; if (wr_cnt !== w0) begin nerr++; $display("FAIL wl_no_write got %0d writes want 0", wr_cnt - w0); end
  endtask

  task automatic test_subword_load;
    int lat;
    mem_word = 32'h8000FF7F;
    access(1'b0, 2'b10, 1'b1, 32'h11, 32'h0, lat);
    nvec++; if (rdata !== 32'hFFFFFFFF) begin nerr++; $display("FAIL bl_sext got %h want ffffffff", rdata); end
    access(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, lat);
    nvec++; if (rdata !== 32'h000000FF) begin nerr++; $display("FAIL bl_zext got %h want 000000ff", rdata); end
    access(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, lat);
    nvec++; if (rdata !== 32'h0000007F) begin nerr++; $display("FAIL bl_lane0 got %h want 0000007f", rdata); end
    access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat);
    nvec++; if (rdata !== 32'hFFFF8000) begin nerr++; $display("FAIL hl_sext got %h want ffff8000", rdata); end
    nvec++; if (lat !== 3) begin nerr++; $display("FAIL hl_latency got %0d want 3", lat); end
  endtask

  task automatic test_store;
    int lat, w0;
    mem_word = 32'h11223344; w0 = wr_cnt;
    access(1'b1, 2'b10, 1'b0, 32'h12, 32'h000000AB, lat);
    nvec++; if (lat !== 5) begin nerr++; $display("FAIL bs_latency got %0d want 5", lat); end
    nvec++; if (wr_cnt - w0 !== 1) begin nerr++; $display("FAIL bs_write_cycles got %0d want 1", wr_cnt - w0); end
    nvec++; if (wr_data !== 32'h11AB3344) begin nerr++; $display("FAIL bs_mem_wdata got %h want 11ab3344", wr_data); end
    nvec++; if (mem_addr !== 32'h10) begin nerr++; $display("FAIL bs_mem_addr got %h want 00000010", mem_addr); end
    w0 = wr_cnt;
    access(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF, lat);
    nvec++; if (wr_data !== 32'hBEEF3344) begin nerr++; $display("FAIL hs_mem_wdata got %h want beef3344", wr_data); end
    nvec++; if (lat !== 5) begin nerr++; $display("FAIL hs_latency got %0d want 5", lat); end
    w0 = wr_cnt;
    access(1'b1, 2'b00, 1'b0, 32'h20, 32'hCAFEF00D, lat);
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL ws_latency got %0d want 1", lat); end
    nvec++; if (wr_data !== 32'hCAFEF00D) begin nerr++; $display("FAIL ws_mem_wdata got %h want cafef00d", wr_data); end
    nvec++; if (wr_cnt - w0 !== 1) begin nerr++; $display("FAIL ws_write_cycles got %0d want 1", wr_cnt - w0); end
  endtask

  task automatic test_misaligned;
    int lat, w0;
    w0 = wr_cnt;
    access(1'b1, 2'b01, 1'b0, 32'h13, 32'h1234, lat);
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL mh_latency got %0d want 1", lat); end
    nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL mh_err got %b want 1", err); end
    access(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, lat);
    nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL sz11_err got %b want 1", err); end
    access(1'b1, 2'b00, 1'b0, 32'h22, 32'h5555, lat);
    nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL mw_err got %b want 1", err); end
    nvec++; if (wr_cnt !== w0) begin nerr++; $display("FAIL err_no_write got %0d writes want 0", wr_cnt - w0); end
  endtask

  task automatic test_reset_wr_wait;
    int lat, d0;
    @(negedge clk);
    for (int i = 0; i < 50 && !ready; i++) @(negedge clk);
    req = 1'b1; op = 1'b1; size = 2'b00; addr = 32'h30; wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 req = 1'b0;
    nvec++; if (mem_write !== 1'b1) begin nerr++; $display("FAIL rw_in_wr_wait got %b want 1", mem_write); end
    d0 = done_cnt;
    #2 reset = 1'b0;
    #1;
    nvec++; if (mem_write !== 1'b0) begin nerr++; $display("FAIL rw_async_write got %b want 0", mem_write); end
    nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL rw_async_ready got %b want 1", ready); end
    nvec++; if (rdata !== 32'h0) begin nerr++; $display("FAIL rw_rdata_clr got %h want 0", rdata); end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    nvec++; if (done_cnt !== d0) begin nerr++; $display("FAIL rw_no_done got %0d pulses want 0", done_cnt - d0); end
    mem_word = 32'h12345678;
    access(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, lat);
    nvec++; if (rdata !== 32'h12345678) begin nerr++; $display("FAIL rw_reload got %h want 12345678", rdata); end
    nvec++; if (lat !== 3) begin nerr++; $display("FAIL rw_reload_lat got %0d want 3", lat); end
  endtask

  task automatic test_back_to_back;
    int d0, lat1, gap;
    logic rdy_after;
    // req toggled while busy must not add a second access
    mem_word = 32'hA5A55A5A;
    @(negedge clk);
    for (int i = 0; i < 50 && !ready; i++) @(negedge clk);
    d0 = done_cnt;
    req = 1'b1; op = 1'b0; size = 2'b00; sext = 1'b0; addr = 32'h10;
    @(posedge clk);
    @(negedge clk) req = 1'b0;
    @(negedge clk) req = 1'b1;
    @(negedge clk) req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    nvec++; if (done_cnt - d0 !== 1) begin nerr++; $display("FAIL busy_done_count got %0d want 1", done_cnt - d0); end
    // req held high across two loads
    @(negedge clk);
    req = 1'b1; addr = 32'h14;
    @(posedge clk);
    lat1 = 0; gap = 0; rdy_after = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat1 = i; break; end
    end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) rdy_after = ready;
      if (done) begin gap = i; break; end
    end
    req = 1'b0;
    nvec++; if (lat1 !== 3) begin nerr++; $display("FAIL b2b_first_lat got %0d want 3", lat1); end
    nvec++; if (rdy_after !== 1'b1) begin nerr++; $display("FAIL b2b_idle_after_resp got %b want 1", rdy_after); end
    nvec++; if (gap !== 5) begin nerr++; $display("FAIL b2b_done_gap got %0d want 5", gap); end
    nvec++; if (rdata !== 32'hA5A55A5A) begin nerr++; $display("FAIL b2b_rdata got %h want a5a55a5a", rdata); end
  endtask

  initial begin
    #12;
    test_reset;
    test_word_load;
    test_subword_load;
    test_store;
    test_misaligned;
    test_reset_wr_wait;
    test_back_to_back;
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
